// File: rtl/ercm8_v2_5_mult.sv
// ercm8_v2_5_mult: configurable approximate 8x8 unsigned multiplier (ERCM V2.5).
// Two register stages: operands/mask are captured first, then the product.
// For every low-order column c (0..6) with mask[c]=1, the partial-product bits
// of that column are replaced by their OR before summation. The OR term sits
// alone in its column, so it never generates a carry, while carries arriving
// from lower exact columns are still added exactly. Columns 7..14 are always
// exact. The mask is a runtime input, so one netlist covers every mask value.
module ercm8_v2_5_mult (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  dat_in_a,
    input  logic [7:0]  dat_in_b,
    input  logic [6:0]  mask,
    output logic [15:0] dat_o
);

    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [6:0]  mask_q;

    logic [7:0]  pp [8];     // pp[i][j] = a[i] & b[j], column i+j
    logic [6:0]  col_or;     // OR of every bit in column c, c = 0..6
    logic [15:0] row [8];    // row i = pp[i] shifted to weight 2^i, after masking
    logic [15:0] prod;

    // Stage 1: capture operands and mask every cycle
    // NOTE: registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            mask_q <= '0;
        end else begin
            a_q    <= dat_in_a;
            b_q    <= dat_in_b;
            mask_q <= mask;
        end
    end

    // Partial products and the OR of each maskable column
    // NOTE: every combinational output gets a default before the loops, so no latch is inferred.
    always_comb begin
        col_or = '0;
        for (int i = 0; i < 8; i++) begin
            pp[i] = b_q & {8{a_q[i]}};
        end
        for (int c = 0; c < 7; c++) begin
            for (int i = 0; i <= c; i++) begin
                col_or[c] = col_or[c] | pp[i][3'(c - i)];
            end
        end
    end

    // Align rows; an approximate column keeps only its OR term, placed in row 0
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            row[i] = 16'(pp[i]) << i;
        end
        for (int c = 0; c < 7; c++) begin
            if (mask_q[c]) begin
                for (int i = 0; i <= c; i++) begin
                    row[i][4'(c)] = (i == 0) ? col_or[c] : 1'b0;
                end
            end
        end
    end

    // Reduce the rows; synthesis maps this sum onto a compressor tree plus final adder
    always_comb begin
        prod = '0;
        for (int i = 0; i < 8; i++) begin
            prod = prod + row[i];
        end
    end

    // Stage 2: register the product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_o <= '0;
        end else begin
            dat_o <= prod;
        end
    end

endmodule

// File: tb/tb_ercm8_v2_5_mult.sv
// Testbench for ercm8_v2_5_mult. Stimulus pushes expected products into a
// scoreboard queue; a monitor tracks a two-stage issue-flag pipeline and pops
// and compares whenever an issued operation reaches dat_o.
module tb_ercm8_v2_5_mult;

    typedef struct {
        logic [15:0] expected;
        logic [15:0] exact;
        bit          stat;      // include in error statistics
    } sb_entry_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [6:0]  m;
    logic [15:0] dat_o;

    sb_entry_t   sb_q [$];
    bit          iss;
    bit          v1, v2;

    int          checks = 0;
    int          errors = 0;

    // error statistics for the characterisation run
    int          n_samp = 0;
    int          n_err  = 0;
    int          max_ed = 0;
    real         sum_ed = 0.0;
    real         sum_red = 0.0;
    int          n_red  = 0;

    ercm8_v2_5_mult dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .dat_in_a (a),
        .dat_in_b (b),
        .mask     (m),
        .dat_o    (dat_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Column-by-column golden model
    function automatic logic [15:0] col_model(input logic [7:0] fa, input logic [7:0] fb,
                                              input logic [6:0] fm);
        int sum = 0;
        for (int c = 0; c < 15; c++) begin
            int cnt = 0;
            for (int i = 0; i < 8; i++) begin
                int j = c - i;
                if (j >= 0 && j < 8) cnt += int'(fa[i] & fb[j]);
            end
            if (c < 7 && fm[c]) sum += (cnt != 0 ? 1 : 0) << c;
            else                sum += cnt << c;
        end
        return sum[15:0];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_le(input string name, input int act, input int lim);
        checks++;
        if (act > lim) begin
            errors++;
            $display("FAIL %s: got %0d, required <= %0d", name, act, lim);
        end
    endtask

    // Drive one operation now and record its expected result
    task automatic drive(input logic [7:0] da, input logic [7:0] db, input logic [6:0] dm,
                         input logic [15:0] exp, input bit st);
        sb_entry_t e;
        a   = da;
        b   = db;
        m   = dm;
        iss = 1'b1;
        e.expected = exp;
        e.exact    = 16'(da * db);
        e.stat     = st;
        sb_q.push_back(e);
    endtask

    task automatic issue(input logic [7:0] da, input logic [7:0] db, input logic [6:0] dm,
                         input logic [15:0] exp, input bit st);
        @(posedge clk);
        #1;
        drive(da, db, dm, exp, st);
    endtask

    // Issue-flag pipeline mirroring the two register stages
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= iss;
            v2 <= v1;
        end
    end

    // Monitor: compare dat_o against the scoreboard on the falling edge
    always @(negedge clk) begin
        if (rst_n && v2) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                sb_entry_t e;
                int ed;
                e = sb_q.pop_front();
                check("dat_o", int'(dat_o), int'(e.expected));
                check_le("one_sided", int'(dat_o), int'(e.exact));
                if (e.stat) begin
                    ed = int'(e.exact) - int'(dat_o);
                    n_samp++;
                    if (ed != 0) n_err++;
                    if (ed > max_ed) max_ed = ed;
                    sum_ed += real'(ed);
                    if (e.exact != 0) begin
                        sum_red += real'(ed) / real'(e.exact);
                        n_red++;
                    end
                end
            end
        end
    end

    // Hand-computed directed vectors
    localparam int N_DIR = 9;
    logic [7:0]  dir_a [N_DIR] = '{8'd3,   8'd3,   8'd255,   8'd255,   8'd0,   8'd255, 8'd7,    8'd15,    8'd200};
    logic [7:0]  dir_b [N_DIR] = '{8'd3,   8'd3,   8'd255,   8'd255,   8'd200, 8'd1,   8'd7,    8'd15,    8'd0};
    logic [6:0]  dir_m [N_DIR] = '{7'h02,  7'h01,  7'h7F,    7'h00,    7'h7F,  7'h7F,  7'h7F,   7'h04,    7'h7F};
    logic [15:0] dir_e [N_DIR] = '{16'd7,  16'd9,  16'd64383, 16'd65025, 16'd0, 16'd255, 16'd31, 16'd217, 16'd0};

    initial begin
        logic [7:0] ra, rb;
        logic [6:0] rm;
        int         wait_cyc;

        rst_n = 1'b0;
        a     = 8'd255;
        b     = 8'd255;
        m     = 7'h00;
        iss   = 1'b0;

        // Reset held with full-scale operands
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_hold", int'(dat_o), 0);

        // Release and issue 3*5; dat_o must still be 0 one edge later
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(8'd3, 8'd5, 7'h00, 16'd15, 1'b0);
        @(posedge clk);
        #1;
        check("latency_early", int'(dat_o), 0);
        drive(dir_a[0], dir_b[0], dir_m[0], dir_e[0], 1'b0);

        for (int k = 1; k < N_DIR; k++) begin
            issue(dir_a[k], dir_b[k], dir_m[k], dir_e[k], 1'b0);
        end

        // Back-to-back random stream with random masks
        for (int k = 0; k < 500; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rm = 7'($urandom_range(0, 127));
            issue(ra, rb, rm, col_model(ra, rb, rm), 1'b0);
        end

        // Reset asserted with products in flight
        issue(8'd10, 8'd20, 7'h00, 16'd200, 1'b0);
        issue(8'd11, 8'd21, 7'h00, 16'd231, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        iss   = 1'b0;
        sb_q.delete();
        #1;
        check("reset_async", int'(dat_o), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Exact mode, exhaustive
        for (int ia = 0; ia < 256; ia++) begin
            for (int ib = 0; ib < 256; ib++) begin
                issue(8'(ia), 8'(ib), 7'h00, 16'(ia * ib), 1'b0);
            end
        end

        // Characterisation with all low columns approximate
        for (int k = 0; k < 10000; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            issue(ra, rb, 7'h7F, col_model(ra, rb, 7'h7F), 1'b1);
        end

        @(posedge clk);
        #1;
        iss = 1'b0;

        // Drain the scoreboard within a bounded number of cycles
        wait_cyc = 0;
        while (sb_q.size() != 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        @(negedge clk);
        check("sb_drain", sb_q.size(), 0);

        check("stat_samples", n_samp, 10000);
        check_le("max_ed", max_ed, 769);
        if (n_samp > 0) begin
            $display("Characterisation: ER=%f MED=%f MRED=%f MNED=%f maxED=%0d",
                     real'(n_err) / real'(n_samp),
                     sum_ed / real'(n_samp),
                     (n_red > 0) ? sum_red / real'(n_red) : 0.0,
                     sum_ed / real'(n_samp) / 65025.0,
                     max_ed);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ercm8_v2_5_mult.md
Name: ercm8_v2_5_mult

Overview:
- Configurable approximate 8x8 unsigned multiplier (ERCM, variant V2.5) with a registered datapath.
- A 7-bit mask selects, per low-order partial-product column (0..6), exact or approximate column compression.
- Mask = 0 gives the exact product.
- Used as a drop-in multiplier where accuracy is traded for area/power, and for error-metric characterisation (ER, MED, MRED, max error).

Parameters:
- None. Widths are fixed: operands 8 bits, mask 7 bits, product 16 bits.

Ports:
- clk       input   1   rising-edge clock
- rst_n     input   1   asynchronous active-low reset
- dat_in_a  input   8   unsigned multiplicand A
- dat_in_b  input   8   unsigned multiplier B
- mask      input   7   mask[c]=1 makes partial-product column c approximate (c = 0..6)
- dat_o     output  16  unsigned (approximate) product

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Stage 1: dat_in_a, dat_in_b and mask are registered on every rising clk edge.
- Stage 2: the combinational multiplier output is registered into dat_o.
- Latency is 2 cycles: inputs present at edge k appear on dat_o after edge k+1.
- Throughput is one operation per cycle. There is no handshake and no stall; dat_o updates every cycle.
- Reset: while rst_n=0, all stage registers and dat_o are 0, asynchronously.
  - After release, dat_o shows 0 until the first sampled operands have propagated through both stages.
  - Reset asserted mid-operation discards any in-flight products.
- Partial products: pp[i][j] = a[i] & b[j], with weight 2^(i+j), column c = i+j, range 0..14.
- Exact column (mask[c]=0, or c >= 7):
  - all bits in the column are summed normally;
  - carries propagate into higher columns.
- Approximate column (mask[c]=1, c <= 6):
  - the column contributes 2^c * OR(all pp in column c);
  - it generates no carry into column c+1;
  - it receives no carries from lower approximate columns.
  - Carries from lower exact columns still enter this column and are added exactly.
  - Equivalently, the column's own bits are replaced by their OR before summation.
- Overall result: dat_o = sum over exact columns of the column bit-sums * 2^c, plus sum over approximate columns of 2^c * OR(col c), truncated to 16 bits.
  - The result never exceeds 16 bits because an approximate contribution is never larger than the exact one.
  - dat_o <= A*B always; the error is one-sided.
- Column 0 has a single bit, so mask[0] has no numeric effect. It is kept for interface compatibility.
- Structure: partial-product reduction is a Dadda tree of full and half adders, followed by a final carry-propagate adder.
  - Approximate columns bypass their compressors and use an OR gate.
  - The OR result is muxed by mask so that one netlist serves every mask value.
- No X propagation from mask: every mask value 0..127 is legal and is decoded statically each cycle.
- Error metric definitions for verification:
  - ED = A*B - dat_o;
  - RED = ED / (A*B) for A*B ≠ 0;
  - normalisation constant for MNED is 65025.

Test Plan:
- Reset: hold rst_n=0 with A=255, B=255 -> dat_o=0. Release rst_n, apply A=3, B=5, mask=0 -> dat_o=15 exactly 2 cycles later. Assert rst_n mid-stream -> dat_o=0 immediately.
- Exact mode: mask=0, exhaustive A,B in 0..255 -> dat_o == A*B for all 65536 pairs, including 255*255=65025 and 0*x=0.
- Single approximate column: A=3, B=3, mask=7'h02 -> dat_o=7 (exact 9). Same with mask=7'h01 -> dat_o=9, since column 0 is unaffected.
- Full approximation: A=255, B=255, mask=7'h7F -> dat_o=64383 (0xFB7F). Exact high part is 64256, plus 127 from the OR'd low columns.
- Pipelining: a back-to-back stream of random A, B, mask with a new value every cycle -> each dat_o matches the golden column model of the inputs applied 2 cycles earlier. There are no bubbles.
- Random characterisation: 10000 random A, B at mask=7'h7F -> dat_o <= A*B for every sample. Report ER, MED, MRED, MNED and max ED; max ED must not exceed 769.
